// File: rtl/zoom_pkg.sv
// Shared definitions for the nearest-neighbour zoom copy engine:
// mode encodings, controller states and mode decode helpers.
package zoom_pkg;

  typedef enum logic [2:0] {
    ZOOM_1X = 3'b000,
    ZOOM_2X = 3'b001,
    ZOOM_4X = 3'b010,
    ZOOM_H  = 3'b011,
    ZOOM_Q  = 3'b100
  } zoom_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } zoom_state_e;

  function automatic logic mode_legal(input logic [2:0] mode);
    return (mode <= ZOOM_Q);
  endfunction

  function automatic logic [1:0] shift_from_mode(input logic [2:0] mode);
    logic [1:0] s;
    case (mode)
      ZOOM_2X, ZOOM_H: s = 2'd1;
      ZOOM_4X, ZOOM_Q: s = 2'd2;
      default:         s = 2'd0;
    endcase
    return s;
  endfunction

  // Half and quarter decimate the source; every other mode replicates it.
  function automatic logic is_zoom_out(input logic [2:0] mode);
    return (mode == ZOOM_H) || (mode == ZOOM_Q);
  endfunction

endpackage

// File: rtl/zoom_copy_engine_pipe_delay.sv
// Fixed-depth shift register that aligns write-side sideband with the
// source memory read latency.
module pipe_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/zoom_copy_engine.sv
// Nearest-neighbour scaler: sweeps the full destination raster once per start,
// fetching centred source pixels and writing background outside the window.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; illegal mode raises a one-cycle error
//   ST_RUN   | one destination pixel issued per clock
//   ST_DRAIN | read pipeline empties into the framebuffer
//   ST_DONE  | single-cycle done pulse, busy already low
module zoom_copy_engine
  import zoom_pkg::*;
#(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int DST_W  = 640,
  parameter int DST_H  = 480,
  parameter int PIX_W  = 8,
  parameter int RD_LAT = 1,
  parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_start,
  input  logic [2:0]                       i_mode,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_error,
  output logic [$clog2(SRC_W*SRC_H)-1:0]   o_src_addr,
  input  logic [PIX_W-1:0]                 i_src_data,
  output logic [$clog2(DST_W*DST_H)-1:0]   o_dst_addr,
  output logic [PIX_W-1:0]                 o_dst_data,
  output logic                             o_dst_wren
);

  localparam int SAW = $clog2(SRC_W*SRC_H);
  localparam int DAW = $clog2(DST_W*DST_H);
  localparam int XW  = $clog2(DST_W);
  localparam int YW  = $clog2(DST_H);
  localparam int CW  = $clog2(4*(SRC_W+SRC_H) + DST_W + DST_H);
  localparam int DCW = $clog2(RD_LAT+1);
  localparam logic [XW-1:0] X_LAST = XW'(DST_W-1);
  localparam logic [YW-1:0] Y_LAST = YW'(DST_H-1);

  zoom_state_e r_state, w_state_nxt;

  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic [DAW-1:0] r_dst_addr;
  logic [SAW-1:0] r_src_hold;
  logic [DCW-1:0] r_drain_cnt;
  logic           r_error;
  logic [1:0]     r_shift;
  logic           r_zoom_out;
  logic [CW-1:0]  r_ow, r_oh, r_offx, r_offy;

  logic           w_accept, w_run, w_last;
  logic [1:0]     w_new_shift;
  logic           w_new_out;
  int             w_ow_i, w_oh_i, w_offx_i, w_offy_i;
  logic [CW-1:0]  w_x, w_y, w_dx, w_dy, w_sx, w_sy;
  logic           w_in_x, w_in_y, w_inside;
  logic [SAW-1:0] w_src_map;
  logic [DAW+1:0] w_pipe_in, w_pipe_out;

  assign w_run    = (r_state == ST_RUN);
  assign w_last   = w_run && (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_accept = (r_state == ST_IDLE) && i_start && mode_legal(i_mode);

  // Window geometry for the requested mode; captured only at an accepted start.
  always_comb begin
    w_new_shift = shift_from_mode(i_mode);
    w_new_out   = is_zoom_out(i_mode);
    w_ow_i      = w_new_out ? (SRC_W >> w_new_shift) : (SRC_W << w_new_shift);
    w_oh_i      = w_new_out ? (SRC_H >> w_new_shift) : (SRC_H << w_new_shift);
    w_offx_i    = (w_ow_i <= DST_W) ? (DST_W - w_ow_i) / 2 : 0;
    w_offy_i    = (w_oh_i <= DST_H) ? (DST_H - w_oh_i) / 2 : 0;
  end

  always_comb begin
    w_x       = CW'(r_x);
    w_y       = CW'(r_y);
    w_dx      = w_x - r_offx;
    w_dy      = w_y - r_offy;
    w_in_x    = (w_x >= r_offx) && (w_dx < r_ow);
    w_in_y    = (w_y >= r_offy) && (w_dy < r_oh);
    w_sx      = r_zoom_out ? (w_dx << r_shift) : (w_dx >> r_shift);
    w_sy      = r_zoom_out ? (w_dy << r_shift) : (w_dy >> r_shift);
    w_inside  = w_in_x && w_in_y && (w_sx < CW'(SRC_W)) && (w_sy < CW'(SRC_H));
    w_src_map = SAW'(w_sy) * SAW'(SRC_W) + SAW'(w_sx);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_drain_cnt == '0) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_dst_addr  <= '0;
      r_src_hold  <= '0;
      r_drain_cnt <= '0;
      r_error     <= 1'b0;
      r_shift     <= '0;
      r_zoom_out  <= 1'b0;
      r_ow        <= '0;
      r_oh        <= '0;
      r_offx      <= '0;
      r_offy      <= '0;
    end else begin
      r_error <= (r_state == ST_IDLE) && i_start && !mode_legal(i_mode);
      if (w_accept) begin
        r_x        <= '0;
        r_y        <= '0;
        r_dst_addr <= '0;
        r_shift    <= w_new_shift;
        r_zoom_out <= w_new_out;
        r_ow       <= CW'(w_ow_i);
        r_oh       <= CW'(w_oh_i);
        r_offx     <= CW'(w_offx_i);
        r_offy     <= CW'(w_offy_i);
      end else if (w_run) begin
        r_dst_addr <= r_dst_addr + 1'b1;
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
        if (w_inside) r_src_hold <= w_src_map;
      end
      // Loaded with RD_LAT so done trails the final write by one idle beat.
      if (w_last) begin
        r_drain_cnt <= DCW'(RD_LAT);
      end else if (r_state == ST_DRAIN && r_drain_cnt != '0) begin
        r_drain_cnt <= r_drain_cnt - 1'b1;
      end
    end
  end

  assign o_src_addr = (w_run && w_inside) ? w_src_map : r_src_hold;

  assign w_pipe_in = {w_run, w_run && w_inside, w_run ? r_dst_addr : '0};

  pipe_delay #(
    .WIDTH (DAW+2),
    .DEPTH (RD_LAT)
  ) u_pipe_delay (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_data  (w_pipe_in),
    .o_data  (w_pipe_out)
  );

  assign o_dst_wren = w_pipe_out[DAW+1];
  assign o_dst_addr = w_pipe_out[DAW-1:0];
  assign o_dst_data = w_pipe_out[DAW+1] ? (w_pipe_out[DAW] ? i_src_data : BG_COLOR) : '0;

  assign o_busy  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign o_done  = (r_state == ST_DONE);
  assign o_error = r_error;

endmodule

// File: tb/tb_zoom_copy_engine.sv
// Scoreboard bench: two engines (read latency 1 and 3) copy randomized source
// images; a behavioural model predicts every framebuffer write.
module tb_zoom_copy_engine;

  localparam int SW  = 16;
  localparam int SH  = 12;
  localparam int DW  = 64;
  localparam int DH  = 48;
  localparam int N   = DW*DH;
  localparam int SAW = $clog2(SW*SH);
  localparam int DAW = $clog2(N);
  localparam logic [7:0] BG = 8'hA5;

  typedef struct {int addr; int data;} exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start;
  logic [2:0] mode;

  logic busy1, done1, err1, wren1, busy3, done3, err3, wren3;
  logic [SAW-1:0] sa1, sa3;
  logic [7:0] sd1, sd3, dd1, dd3;
  logic [DAW-1:0] da1, da3;

  zoom_copy_engine #(.SRC_W(SW), .SRC_H(SH), .DST_W(DW), .DST_H(DH), .PIX_W(8),
                     .RD_LAT(1), .BG_COLOR(BG)) u_dut1 (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_mode(mode),
    .o_busy(busy1), .o_done(done1), .o_error(err1), .o_src_addr(sa1),
    .i_src_data(sd1), .o_dst_addr(da1), .o_dst_data(dd1), .o_dst_wren(wren1));

  zoom_copy_engine #(.SRC_W(SW), .SRC_H(SH), .DST_W(DW), .DST_H(DH), .PIX_W(8),
                     .RD_LAT(3), .BG_COLOR(BG)) u_dut3 (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_mode(mode),
    .o_busy(busy3), .o_done(done3), .o_error(err3), .o_src_addr(sa3),
    .i_src_data(sd3), .o_dst_addr(da3), .o_dst_data(dd3), .o_dst_wren(wren3));

  logic [7:0] mem [SW*SH];
  logic [7:0] pipe1 [1];
  logic [7:0] pipe3 [3];
  always @(posedge clk) begin
    pipe1[0] <= mem[sa1];
    pipe3[0] <= mem[sa3];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign sd1 = pipe1[0];
  assign sd3 = pipe3[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  exp_t q1[$], q3[$];
  logic [7:0] fb1 [N];
  logic [7:0] fb3 [N];
  int c0_1 = 0, c0_3 = 0, wc1 = 0, wc3 = 0;
  bit done1_seen, done3_seen;
  logic busy1_q = 1'b0, busy3_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Spec-level reference: scale factor, centred window, replicate or decimate.
  function automatic int ref_pix(input int x, input int y, input int m);
    int f, ow, oh, ox, oy, dx, dy, sx, sy;
    bit zin;
    f   = (m == 1 || m == 3) ? 2 : (m == 2 || m == 4) ? 4 : 1;
    zin = (m <= 2);
    ow  = zin ? SW*f : SW/f;
    oh  = zin ? SH*f : SH/f;
    ox  = (ow <= DW) ? (DW-ow)/2 : 0;
    oy  = (oh <= DH) ? (DH-oh)/2 : 0;
    dx  = x - ox;
    dy  = y - oy;
    if (dx < 0 || dx >= ow || dy < 0 || dy >= oh) return int'(BG);
    sx = zin ? dx/f : dx*f;
    sy = zin ? dy/f : dy*f;
    if (sx >= SW || sy >= SH) return int'(BG);
    return int'(mem[sy*SW+sx]);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (busy1 && !busy1_q) begin c0_1 = cyc; wc1 = 0; end
    busy1_q = busy1;
    if (wren1) begin
      if (wc1 == 0) chk("first_write_lat1", cyc - c0_1, 1);
      wc1++;
      chk("pending_write1", q1.size() > 0, 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("dst_addr1", da1, e.addr);
        chk("dst_data1", dd1, e.data);
        fb1[da1] = dd1;
      end
    end
    if (done1) begin
      chk("done_time1", cyc - c0_1, N+1+1);
      chk("write_count1", wc1, N);
      chk("busy_with_done1", busy1, 0);
      done1_seen = 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy3 && !busy3_q) begin c0_3 = cyc; wc3 = 0; end
    busy3_q = busy3;
    if (wren3) begin
      if (wc3 == 0) chk("first_write_lat3", cyc - c0_3, 3);
      wc3++;
      chk("pending_write3", q3.size() > 0, 1);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        chk("dst_addr3", da3, e.addr);
        chk("dst_data3", dd3, e.data);
        fb3[da3] = dd3;
      end
    end
    if (done3) begin
      chk("done_time3", cyc - c0_3, N+3+1);
      chk("write_count3", wc3, N);
      chk("busy_with_done3", busy3, 0);
      done3_seen = 1;
    end
  end

  task automatic load_frame(input int m);
    exp_t e;
    for (int i = 0; i < SW*SH; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < N; i++) begin fb1[i] = 8'h00; fb3[i] = 8'h00; end
    for (int a = 0; a < N; a++) begin
      e.addr = a;
      e.data = ref_pix(a % DW, a / DW, m);
      q1.push_back(e);
      q3.push_back(e);
    end
  endtask

  task automatic start_frame(input int m);
    done1_seen = 0;
    done3_seen = 0;
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 3'(m);
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(done1_seen && done3_seen) && n < 2*N) begin
      @(posedge clk);
      n++;
    end
    chk(name, done1_seen && done3_seen, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic px(input string name, input int x, input int y, input logic [7:0] exp);
    chk({name, "_lat1"}, fb1[y*DW+x], exp);
    chk({name, "_lat3"}, fb3[y*DW+x], exp);
  endtask

  task automatic run_frame(input int m, input string name);
    load_frame(m);
    start_frame(m);
    wait_done(name);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    chk("rst_error1", err1, 0);
    chk("rst_wren1", wren1, 0);
    chk("rst_src_addr1", sa1, 0);
    chk("rst_dst_addr1", da1, 0);
    chk("rst_dst_data1", dd1, 0);
    chk("rst_busy3", busy3, 0);
    chk("rst_wren3", wren3, 0);
    rst_n = 1'b1;

    run_frame(0, "frame_1x");
    px("1x_origin", 24, 18, mem[0]);
    px("1x_bg_corner", 0, 0, BG);
    px("1x_last_src", 24+SW-1, 18+SH-1, mem[SW*SH-1]);

    // 2x with a start pulse mid-frame that must be ignored
    load_frame(1);
    start_frame(1);
    repeat (100) @(posedge clk);
    #1 start = 1'b1; mode = 3'd4;
    @(posedge clk); #1 start = 1'b0;
    wait_done("frame_2x");
    px("2x_origin", 16, 12, mem[0]);
    px("2x_dup_x", 17, 12, mem[0]);
    px("2x_next", 18, 12, mem[1]);
    px("2x_dup_y", 16, 13, mem[0]);
    px("2x_bg", 0, 0, BG);

    run_frame(2, "frame_4x");
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        px("4x_block", x, y, mem[0]);
    px("4x_next", 4, 0, mem[1]);

    run_frame(3, "frame_half");
    px("half_origin", 28, 21, mem[0]);
    px("half_decim", 29, 21, mem[2]);
    px("half_bg", 27, 21, BG);

    run_frame(4, "frame_quarter");
    px("quarter_decim", 31, 22, mem[4]);
    px("quarter_bg_above", 30, 21, BG);

    // illegal modes
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start = 1'b1;
      mode  = (k == 0) ? 3'b101 : 3'($urandom_range(5, 7));
      @(posedge clk); #1;
      start = 1'b0;
      chk("illegal_error1", err1, 1);
      chk("illegal_error3", err3, 1);
      chk("illegal_busy1", busy1, 0);
      @(posedge clk); #1;
      chk("illegal_error_pulse1", err1, 0);
      chk("illegal_busy_after1", busy1, 0);
      chk("illegal_busy_after3", busy3, 0);
    end

    // reset mid-frame near y=30
    load_frame(1);
    start_frame(1);
    repeat (30*DW) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_wren1", wren1, 0);
    chk("midrst_wren3", wren3, 0);
    chk("midrst_busy1", busy1, 0);
    chk("midrst_busy3", busy3, 0);
    q1.delete();
    q3.delete();
    @(posedge clk); #1 rst_n = 1'b1;

    run_frame(1, "frame_2x_after_reset");
    px("2x_rerun_origin", 16, 12, mem[0]);
    px("2x_rerun_dup", 17, 12, mem[0]);
    px("2x_rerun_next", 18, 12, mem[1]);

    for (int k = 0; k < 2; k++) run_frame(int'($urandom_range(0, 4)), "frame_random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
